// File: rtl/apb_bridge_ctrl.sv
// apb_bridge_ctrl: AHB-lite to APB bridge with one-hot select, access timeout and error counting
module apb_bridge_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSEL    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              Valid,
  input  logic              Hwrite,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic              Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [NSEL-1:0]   Psel,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic [7:0]        err_cnt
);
  localparam int IW = $clog2(NSEL);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_wait;
  logic w_accept, w_timeout, w_done;
  // next state; the last permitted ACCESS cycle times out even if Pready arrives in it
  always_comb begin
    w_accept  = (r_state == IDLE || r_state == ERR2) && Valid;
    w_timeout = (TIMEOUT > 0) && r_state == ACCESS && r_wait == TO_LAST;
    w_done    = r_state == ACCESS && !w_timeout && Pready;
    w_next    = r_state;
    unique case (r_state)
      IDLE, ERR2: w_next = w_accept ? (Hwrite ? WDATA : SETUP) : IDLE;
      WDATA:      w_next = SETUP;
      SETUP:      w_next = ACCESS;
      ACCESS:     w_next = w_timeout ? ERR1 : !Pready ? ACCESS : Pslverr ? ERR1 : IDLE;
      ERR1:       w_next = ERR2;
      default:    w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge Hclk) begin
    if (Hreset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // address/data capture, wait counter and saturating error counter
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      Pwdata  <= '0;
      Hrdata  <= '0;
      r_idx   <= '0;
      r_wait  <= '0;
      err_cnt <= '0;
    end else begin
      if (w_accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        r_idx  <= Haddr[SEL_LSB +: IW];
      end
      if (r_state == WDATA) Pwdata <= Hwdata;
      if (r_state == ACCESS && !Pready) r_wait <= r_wait + CW'(1);
      else if (w_next == SETUP) r_wait <= '0;
      if (w_done && !Pslverr && !Pwrite) Hrdata <= Prdata;
      if (r_state == ERR2 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
  assign Hreadyout = r_state == IDLE || r_state == ERR2;
  assign Hresp     = r_state == ERR1 || r_state == ERR2;
  assign Penable   = r_state == ACCESS;
  assign Psel      = (r_state == SETUP || r_state == ACCESS) ? NSEL'(1) << r_idx : '0;
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb_apb_bridge_ctrl: randomized transaction-level check of apb_bridge_ctrl against a spec model
module tb_apb_bridge_ctrl;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        rst, valid, hwrite, hreadyout, hresp, penable, pwrite, pready, pslverr;
  logic [31:0] haddr, hwdata, hrdata, paddr, pwdata, prdata;
  logic [3:0]  psel;
  logic [7:0]  err_cnt;
  int          n_chk = 0, n_bad = 0, m_errs = 0;
  logic [31:0] m_rd = '0;
  apb_bridge_ctrl dut (
    .Hclk(clk), .Hreset(rst), .Valid(valid), .Hwrite(hwrite), .Haddr(haddr), .Hwdata(hwdata),
    .Hreadyout(hreadyout), .Hresp(hresp), .Hrdata(hrdata), .Psel(psel), .Penable(penable),
    .Pwrite(pwrite), .Paddr(paddr), .Pwdata(pwdata), .Pready(pready), .Pslverr(pslverr),
    .Prdata(prdata), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic noise();
    valid  = 1'($urandom);
    hwrite = 1'($urandom);
    haddr  = $urandom;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      valid = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int wt, input bit se);
    logic [3:0] sel;
    bit to, err;
    int n;
    sel = 4'(1 << ((addr >> 12) % 4));
    to  = wt + 1 >= TO;
    n   = to ? TO : wt + 1;
    err = to || se;
    chk("ready_at_accept", 32'(hreadyout), 1);
    valid = 1'b1; hwrite = wr; haddr = addr; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    noise();
    hwdata = $urandom;
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    if (wr) begin
      chk("wdata_ready", 32'(hreadyout), 0);
      chk("wdata_psel", 32'(psel), 0);
      hwdata = wd;
      @(negedge clk);
      hwdata = $urandom;
      noise();
    end
    chk("setup_psel", 32'(psel), 32'(sel));
    chk("setup_penable", 32'(penable), 0);
    chk("setup_ready", 32'(hreadyout), 0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", 32'(pwrite), 32'(wr));
    if (wr) chk("setup_pwdata", pwdata, wd);
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      chk("access_penable", 32'(penable), 1);
      chk("access_psel", 32'(psel), 32'(sel));
      chk("access_ready", 32'(hreadyout), 0);
      pready  = i == wt + 1;
      pslverr = pready ? se : 1'($urandom);
      prdata  = pready ? rd : $urandom;
      @(negedge clk);
      noise();
    end
    pready = 1'b0; pslverr = 1'b0;
    if (err) begin
      chk("err1_resp", 32'(hresp), 1);
      chk("err1_ready", 32'(hreadyout), 0);
      chk("err1_psel", 32'(psel), 0);
      chk("err1_penable", 32'(penable), 0);
      @(negedge clk);
      noise();
      chk("err2_resp", 32'(hresp), 1);
      chk("err2_ready", 32'(hreadyout), 1);
      if (m_errs < 255) m_errs++;
    end else begin
      chk("done_ready", 32'(hreadyout), 1);
      chk("done_resp", 32'(hresp), 0);
      chk("done_psel", 32'(psel), 0);
      chk("done_penable", 32'(penable), 0);
      if (!wr) m_rd = rd;
    end
    chk("hrdata", hrdata, m_rd);
    chk("hold_paddr", paddr, addr);
    chk("hold_pwrite", 32'(pwrite), 32'(wr));
    valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(hreadyout), 1);
    chk("rst_resp", 32'(hresp), 0);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h0000_3000;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_penable", 32'(penable), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_psel", 32'(psel), 0);
    chk("mid_rst_penable", 32'(penable), 0);
    chk("mid_rst_ready", 32'(hreadyout), 1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    idle(2);
    txn(0, 32'h0000_2010, 32'h0, 32'hCAFE_0001, 0, 0);
    txn(1, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0);
    txn(0, 32'h0000_0008, 32'h0, 32'h5555_AAAA, 5, 0);
    txn(0, 32'h0000_3000, 32'h0, 32'h1111_2222, 100, 0);
    txn(0, 32'h0000_2000, 32'h0, 32'h3333_4444, 0, 1);
    txn(0, 32'h0000_1000, 32'h0, 32'h7777_8888, 0, 0);
    txn(0, 32'h0000_0ABC, 32'h0, 32'h9999_0000, TO - 2, 0);
    txn(0, 32'h0000_0ABC, 32'h0, 32'h9999_0001, TO - 1, 0);
    for (int t = 0; t < 150; t++) begin
      int w;
      w = ($urandom % 8 == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 4));
      txn(1'($urandom), $urandom, $urandom, $urandom, w, $urandom % 6 == 0);
      if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
    end
    for (int t = 0; t < 260; t++) txn(1'($urandom), $urandom, $urandom, $urandom, 0, 1);
    idle(1);
    chk("err_cnt_sat", 32'(err_cnt), 255);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_errs = 0; m_rd = '0;
    chk("rst2_err_cnt", 32'(err_cnt), 0);
    chk("rst2_hrdata", hrdata, 0);
    txn(0, 32'h0000_2010, 32'h0, 32'hCAFE_0001, 0, 0);
    idle(1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
